// File: rtl/intxn_phase_sched.sv
// Phase scheduler for the highway/side-road intersection: shares green time between
// the E/W car sensor, the pedestrian button and the emergency pre-empt, with its own 1 s time base.
module intxn_phase_sched #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int MIN_GREEN   = 10,
  parameter int YELLOW_SEC  = 2,
  parameter int ALL_RED_SEC = 1,
  parameter int SIDE_GREEN  = 5,
  parameter int WALK_SEC    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       ped,
  input  logic       emerg,
  output logic [5:0] lights,
  output logic       walk,
  output logic [2:0] phase,
  output logic       sec_tick
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);
  localparam logic [5:0] SEC_MAX  = 6'd63;
  localparam logic [5:0] MIN_SEC  = 6'(MIN_GREEN);
  localparam logic [5:0] MIN_LAST = 6'(MIN_GREEN - 1);
  localparam logic [5:0] YEL_LAST = 6'(YELLOW_SEC - 1);
  localparam logic [5:0] AR_LAST  = 6'(ALL_RED_SEC - 1);
  localparam logic [5:0] EW_LAST  = 6'(SIDE_GREEN - 1);
  localparam logic [5:0] WK_LAST  = 6'(WALK_SEC - 1);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    ALL_R = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    WALK  = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [5:0]    lights_reg, lights_next;
  logic          walk_reg, walk_next;
  logic [PW-1:0] presc_reg;
  logic [5:0]    sec_reg;
  logic [1:0]    pend_reg;   // [0] = car_p, [1] = ped_p
  logic [1:0]    pend_req;
  logic [1:0]    pend_clr;
  logic          entering;
  logic          legal;
  logic          min_met, done_yel, done_ar, done_ew, done_wk;

  assign sec_tick = (presc_reg == PRESC_MAX);
  assign entering = (state_next != state_reg);

  // The last tick of the minimum green counts as met so NS_G lasts exactly MIN_GREEN seconds.
  assign min_met  = (sec_reg >= MIN_SEC) || (sec_tick && (sec_reg == MIN_LAST));
  assign done_yel = sec_tick && (sec_reg == YEL_LAST);
  assign done_ar  = sec_tick && (sec_reg == AR_LAST);
  assign done_ew  = sec_tick && (sec_reg == EW_LAST);
  assign done_wk  = sec_tick && (sec_reg == WK_LAST);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= NS_G;
      lights_reg <= 6'b100001;
      walk_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lights_reg <= lights_next;
      walk_reg   <= walk_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NS_G:  if (min_met && (pend_reg[0] || pend_reg[1]) && !emerg) state_next = NS_Y;
      NS_Y:  if (done_yel) state_next = ALL_R;
      ALL_R: if (done_ar) begin
               if (emerg)            state_next = NS_G;
               else if (pend_reg[1]) state_next = WALK;
               else                  state_next = EW_G;
             end
      EW_G:  if (emerg || done_ew) state_next = EW_Y;
      EW_Y:  if (done_yel) state_next = NS_G;
      WALK:  if (done_wk) state_next = (pend_reg[0] && !emerg) ? EW_G : NS_G;
      default: state_next = NS_G;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the state.
  always_comb begin
    lights_next = 6'b001001;
    walk_next   = 1'b0;
    case (state_next)
      NS_G:  lights_next = 6'b100001;
      NS_Y:  lights_next = 6'b010001;
      ALL_R: lights_next = 6'b001001;
      EW_G:  lights_next = 6'b001100;
      EW_Y:  lights_next = 6'b001010;
      WALK:  begin
               lights_next = 6'b001001;
               walk_next   = 1'b1;
             end
      default: lights_next = 6'b001001;
    endcase
  end

  // Timers restart on every state entry; sec saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset || entering) begin
      presc_reg <= '0;
      sec_reg   <= '0;
    end else if (sec_tick) begin
      presc_reg <= '0;
      if (sec_reg != SEC_MAX) sec_reg <= sec_reg + 6'd1;
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

  assign pend_req = {ped, car};
  assign pend_clr = {(state_next == WALK) && (state_reg != WALK),
                     (state_next == EW_G) && (state_reg != EW_G)};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pend
      always_ff @(posedge clk) begin
        if (reset) pend_reg[gi] <= 1'b0;
        else       pend_reg[gi] <= (pend_reg[gi] & ~pend_clr[gi]) | pend_req[gi];
      end
    end
  endgenerate

  // Encodings 6/7 show all-red until the next edge returns to NS_G.
  assign legal  = (state_reg <= WALK);
  assign lights = legal ? lights_reg : 6'b001001;
  assign walk   = legal & walk_reg;
  assign phase  = state_reg;

endmodule

// File: doc/intxn_phase_sched.md
# intxn_phase_sched

Phase scheduler for the highway/side-road intersection. It shares the intersection's green time between three requesters: the east/west car sensor, the pedestrian push-button and the highway emergency pre-empt. It sequences the six traffic-light outputs plus a walk signal through safe yellow and all-red clearances. It replaces the fixed four-state controller and owns its own one-second time base, derived from the 50 MHz board clock.

## Interface
- CLK_PER_SEC, 50000000: clk cycles per second tick.
- MIN_GREEN, 10: minimum N/S green, in seconds.
- YELLOW_SEC, 2: yellow duration, in seconds, both roads.
- ALL_RED_SEC, 1: all-red clearance after N/S yellow, in seconds.
- SIDE_GREEN, 5: E/W green duration, in seconds.
- WALK_SEC, 6: pedestrian walk duration, in seconds.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- car  in  1  E/W car sensor, level, synchronous to clk.
- ped  in  1  pedestrian button, level or pulse.
- emerg  in  1  highway emergency pre-empt, level.
- lights  out  6  [5:3] = N/S {G,Y,R}, [2:0] = E/W {G,Y,R}.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding, for debug.
- sec_tick  out  1  one-cycle pulse per elapsed second.

## Operation
- States and their outputs (phase / lights / walk):
  - NS_G: 0 / 100001 / 0
  - NS_Y: 1 / 010001 / 0
  - ALL_R: 2 / 001001 / 0
  - EW_G: 3 / 001100 / 0
  - EW_Y: 4 / 001010 / 0
  - WALK: 5 / 001001 / 1
- Pending flags car_p and ped_p:
  - Update rule: p_next = (p & ~clr) | req. A set in the same cycle as a clear wins.
  - car_p is cleared on entry to EW_G.
  - ped_p is cleared on entry to WALK.
- Time base:
  - The prescaler counts 0..CLK_PER_SEC-1. sec_tick pulses on the wrap cycle.
  - The seconds counter sec (6 bits) increments on sec_tick.
  - Prescaler and sec both restart at 0 on every state entry, so a state of duration D lasts exactly D*CLK_PER_SEC cycles.
  - sec saturates at 63.
- Transitions are evaluated on a cycle with sec_tick=1 and sec==D-1, called "done(D)":
  - NS_G -> NS_Y when sec>=MIN_GREEN and (car_p|ped_p) and !emerg.
    - The sec>=MIN_GREEN test uses the saturating counter, so the exit can occur on any cycle once the minimum green is met.
    - While emerg=1, the block holds NS_G indefinitely.
  - NS_Y -> ALL_R on done(YELLOW_SEC).
  - ALL_R on done(ALL_RED_SEC):
    - goes to NS_G if emerg,
    - else to WALK if ped_p,
    - else to EW_G.
  - EW_G -> EW_Y on done(SIDE_GREEN). It also exits on the first cycle with emerg=1 (truncation).
  - EW_Y -> NS_G on done(YELLOW_SEC).
  - WALK on done(WALK_SEC):
    - goes to EW_G if car_p and !emerg,
    - else to NS_G.
    - Walk is never truncated.
- Pedestrian service has priority over car service at the ALL_R decision. Emergency has priority over both.
- A car held high through EW_G re-arms car_p. The next side cycle is then bounded by MIN_GREEN, so the highway is never starved.

## Timing
- Reset values:
  - state NS_G, so lights=100001, walk=0, phase=0.
  - car_p=ped_p=0, prescaler=0, sec=0, sec_tick=0.
- The first cycle after reset deassertion counts as the first cycle of NS_G.
- State, lights, walk and phase are all registered. They change on the same clk edge, with no extra cycle of decode latency.
- Request latency: a request sampled at edge k is pending at edge k+1. It can cause NS_G exit at edge k+1 at the earliest, provided min green is already met.
- Emerg truncation of EW_G: EW_Y is entered at the edge after emerg is first sampled high.
- Reset asserted mid-operation:
  - The next edge forces NS_G and clears pendings and timers, regardless of state.
  - Requests sampled while reset=1 are discarded.
- Widths:
  - The prescaler is $clog2(CLK_PER_SEC) bits.
  - All duration parameters must be in the range 1..63.
  - No illegal state is reachable. Encodings 6 and 7 decode to NS_G on the next edge, with lights=001001 while in them.

## Test plan
All scenarios use CLK_PER_SEC=4, MIN_GREEN=3, YELLOW_SEC=2, ALL_RED_SEC=1, SIDE_GREEN=3, WALK_SEC=2.

1. Reset, then pulse car for 1 cycle at cycle 2 -> lights sequence is:
   - 100001 for 12 cycles,
   - 010001 for 8,
   - 001001 for 4,
   - 001100 for 12,
   - 001010 for 8,
   - then 100001 holding.
2. Idle with no requests for 200 cycles -> lights stay 100001 and phase stays 0. sec saturates at 63 without wrap; extend the run to 300 cycles to check saturation.
3. car and ped both pulsed at cycle 1 -> NS_Y, then ALL_R, then WALK (walk=1, lights=001001) for 8 cycles, then EW_G for 12 cycles, then EW_Y, then NS_G. Both pendings read 0 at the end.
4. Car request, then emerg raised on the 3rd cycle of EW_G -> EW_Y is entered at the next edge, then NS_G. NS_G is held while emerg=1 even with car high.
5. emerg high during ALL_R with car_p set -> ALL_R goes to NS_G and car_p remains 1. After emerg drops, NS_Y starts once MIN_GREEN has elapsed.
6. reset pulsed for 1 cycle mid-EW_G -> the next edge gives lights=100001, walk=0, and sec_tick stays 0 for the next 3 cycles.
